// File: rtl/mux_pkg.sv
// Shared constants and FSM state type for the 8:1 TDM multiplexer.
package mux_pkg;

   localparam int CH_N  = 8;
   localparam int SEL_W = 3;

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } mux_state_e;

endpackage

// File: rtl/rr_pick_8.sv
// Channel selector: one-hot grant, index and any-flag from req and ptr.
// MUX_SKIP_IDLE_EN selects work-conserving round robin; default is fixed TDM slot.
module rr_pick_8
   import mux_pkg::*;
(
   input  logic [CH_N-1:0]  req,
   input  logic [SEL_W-1:0] ptr,
   output logic [CH_N-1:0]  grant,
   output logic [SEL_W-1:0] idx,
   output logic             any
);

`ifdef MUX_SKIP_IDLE_EN
   logic [SEL_W-1:0] cand;

   // First requester found scanning upward from ptr, wrapping 7 -> 0.
   always_comb begin
      grant = '0;
      idx   = ptr;
      any   = 1'b0;
      cand  = '0;
      for (int unsigned i = 0; i < CH_N; i++) begin
         cand = ptr + SEL_W'(i);
         if (!any && req[cand]) begin
            any   = 1'b1;
            idx   = cand;
            grant = CH_N'(1) << cand;
         end
      end
   end
`else
   assign any   = req[ptr];
   assign idx   = ptr;
   assign grant = any ? (CH_N'(1) << ptr) : '0;
`endif

endmodule

// File: rtl/mux_8x1_tdm.sv
// 8:1 time-division multiplexer with one-word output register and source index.
// Build option MUX_SKIP_IDLE_EN: skip idle slots (round robin) instead of fixed TDM.
module mux_8x1_tdm
   import mux_pkg::*;
#(
   parameter int DATA_W = 1
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [CH_N-1:0]        req,
   input  logic [CH_N*DATA_W-1:0] d,
   output logic [CH_N-1:0]        ack,
   output logic [DATA_W-1:0]      y,
   output logic [SEL_W-1:0]       s,
   output logic                   y_valid,
   input  logic                   out_ready
);

   mux_state_e       state;
   logic [SEL_W-1:0] ptr;
   logic [CH_N-1:0]  pick_grant;
   logic [SEL_W-1:0] pick_idx;
   logic             pick_any;
   logic             loadable;
   logic [DATA_W-1:0] pick_data;

   rr_pick_8 u_pick (
      .req   (req),
      .ptr   (ptr),
      .grant (pick_grant),
      .idx   (pick_idx),
      .any   (pick_any)
   );

   assign loadable = (state == EMPTY) || out_ready;
   assign ack      = (rst_n && loadable) ? pick_grant : '0;

   always_comb begin
      pick_data = '0;
      for (int unsigned k = 0; k < CH_N; k++) begin
         if (pick_idx == SEL_W'(k)) pick_data = d[k*DATA_W +: DATA_W];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= EMPTY;
         y_valid <= 1'b0;
         y       <= '0;
         s       <= '0;
         ptr     <= '0;
      end else if (loadable) begin
         if (pick_any) begin
            state   <= FULL;
            y_valid <= 1'b1;
            y       <= pick_data;
            s       <= pick_idx;
         end else begin
            state   <= EMPTY;
            y_valid <= 1'b0;
         end
`ifdef MUX_SKIP_IDLE_EN
         if (pick_any) ptr <= pick_idx + SEL_W'(1);
`else
         // Slot pointer moves on every loadable cycle, granted or not.
         ptr <= ptr + SEL_W'(1);
`endif
      end
   end

endmodule

// File: tb/tb_mux_8x1_tdm.sv
// Self-checking bench for mux_8x1_tdm against a slot/round-robin reference model.
module tb_mux_8x1_tdm;

   localparam int DW = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [7:0]    req = '0;
   logic [8*DW-1:0] d = '0;
   logic [7:0]    ack;
   logic [DW-1:0] y;
   logic [2:0]    s;
   logic          y_valid;
   logic          out_ready = 1'b0;

   int n_chk = 0;
   int n_fail = 0;

   int            m_ptr = 0;
   bit            m_valid = 0;
   logic [DW-1:0] m_y = '0;
   int            m_s = 0;
   logic [7:0]    m_ack = '0;

   mux_8x1_tdm #(.DATA_W(DW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req),
      .d         (d),
      .ack       (ack),
      .y         (y),
      .s         (s),
      .y_valid   (y_valid),
      .out_ready (out_ready)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] exp_ack();
      if (!rst_n || (m_valid && !out_ready)) return 8'h00;
`ifdef MUX_SKIP_IDLE_EN
      for (int i = 0; i < 8; i++) begin
         if (req[(m_ptr + i) % 8]) return 8'h01 << ((m_ptr + i) % 8);
      end
`else
      if (req[m_ptr]) return 8'h01 << m_ptr;
`endif
      return 8'h00;
   endfunction

   // Advance the model with the inputs present before the edge, then cross the edge.
   task automatic tick();
      logic [7:0] a;
      bit ld;
      a  = exp_ack();
      ld = !m_valid || out_ready;
      if (!rst_n) begin
         m_ptr = 0; m_valid = 0; m_y = '0; m_s = 0;
      end else if (ld) begin
         if (a != 8'h00) begin
            for (int k = 0; k < 8; k++) begin
               if (a[k]) begin
                  m_s = k; m_y = d[k*DW +: DW]; m_ptr = (k + 1) % 8;
               end
            end
            m_valid = 1;
         end else begin
            m_valid = 0;
`ifndef MUX_SKIP_IDLE_EN
            m_ptr = (m_ptr + 1) % 8;
`endif
         end
      end
      m_ack = a;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      req = '0;
      tick();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; req = 8'hFF; out_ready = 1'($urandom_range(0, 1)); d = $urandom();
      #1;
      n_chk++; if (ack !== 8'h00) begin n_fail++; $display("FAIL reset_ack: ack=%h required 00", ack); end
      tick(); tick();
      n_chk++;
      if (y_valid !== 1'b0 || s !== 3'd0 || y !== '0) begin
         n_fail++; $display("FAIL reset_out: y_valid=%b s=%0d y=%h required 0 0 0", y_valid, s, y);
      end
      n_chk++; if (ack !== 8'h00) begin n_fail++; $display("FAIL reset_ack_hold: ack=%h required 00", ack); end
      rst_n = 1'b1; req = '0;
   endtask

   task automatic test_single();
      logic [7:0] e;
      bit seen;
      do_reset();
      req = 8'h10; out_ready = 1'b1; d = $urandom(); d[4*DW +: DW] = 4'hA; seen = 0;
      for (int c = 0; c < 16 && !seen; c++) begin
         #1;
         e = exp_ack();
         n_chk++; if (ack !== e) begin n_fail++; $display("FAIL single_ack: ack=%h required %h", ack, e); end
         n_chk++; if (y_valid !== m_valid) begin n_fail++; $display("FAIL single_idle: y_valid=%b required %b", y_valid, m_valid); end
         if (ack === 8'h10) seen = 1;
         tick();
      end
      n_chk++; if (!seen) begin n_fail++; $display("FAIL single_timeout: ack=%h required 10 within 16 cycles", ack); end
      req = '0;
      #1;
      n_chk++;
      if (y_valid !== 1'b1 || s !== 3'd4 || y !== 4'hA) begin
         n_fail++; $display("FAIL single_word: y_valid=%b s=%0d y=%h required 1 4 a", y_valid, s, y);
      end
      tick();
   endtask

   task automatic test_all();
      do_reset();
      req = 8'hFF; out_ready = 1'b1;
      for (int c = 0; c < 10; c++) begin
         d = $urandom();
         #1;
         n_chk++;
         if (ack !== (8'h01 << (c % 8))) begin
            n_fail++; $display("FAIL all_ack: cycle %0d ack=%h required %h", c, ack, 8'h01 << (c % 8));
         end
         tick();
         n_chk++;
         if (y_valid !== 1'b1 || s !== 3'(c % 8) || y !== m_y) begin
            n_fail++; $display("FAIL all_word: cycle %0d y_valid=%b s=%0d y=%h required 1 %0d %h", c, y_valid, s, y, c % 8, m_y);
         end
      end
      req = '0;
   endtask

   task automatic test_stall();
      logic [7:0] e;
      bit seen;
      do_reset();
      req = 8'h04; out_ready = 1'b0; d = $urandom(); seen = 0;
      for (int c = 0; c < 16 && !seen; c++) begin
         #1;
         e = exp_ack();
         n_chk++; if (ack !== e) begin n_fail++; $display("FAIL stall_load_ack: ack=%h required %h", ack, e); end
         if (ack === 8'h04) seen = 1;
         tick();
      end
      n_chk++; if (!seen) begin n_fail++; $display("FAIL stall_timeout: ack=%h required 04 within 16 cycles", ack); end
      req = 8'h20; d = $urandom();
      for (int c = 0; c < 3; c++) begin
         #1;
         n_chk++;
         if (ack !== 8'h00 || y_valid !== 1'b1 || s !== 3'd2 || y !== m_y) begin
            n_fail++; $display("FAIL stall_hold: ack=%h y_valid=%b s=%0d y=%h required 00 1 2 %h", ack, y_valid, s, y, m_y);
         end
         tick();
      end
      out_ready = 1'b1; seen = 0;
      for (int c = 0; c < 16 && !seen; c++) begin
         #1;
         e = exp_ack();
         n_chk++; if (ack !== e) begin n_fail++; $display("FAIL stall_release_ack: ack=%h required %h", ack, e); end
         if (ack === 8'h20) seen = 1;
         tick();
      end
      n_chk++; if (!seen) begin n_fail++; $display("FAIL stall_release_timeout: ack=%h required 20", ack); end
      req = '0;
      #1;
      n_chk++;
      if (y_valid !== 1'b1 || s !== 3'd5 || y !== m_y) begin
         n_fail++; $display("FAIL stall_next: y_valid=%b s=%0d y=%h required 1 5 %h", y_valid, s, y, m_y);
      end
      tick();
   endtask

   task automatic test_wrap();
      logic [7:0] e;
      bit seen;
      do_reset();
      req = 8'h81; out_ready = 1'b1; d = $urandom(); seen = 0;
      for (int c = 0; c < 20 && !seen; c++) begin
         #1;
         e = exp_ack();
         n_chk++; if (ack !== e) begin n_fail++; $display("FAIL wrap_ack: ack=%h required %h", ack, e); end
         if (ack === 8'h80) seen = 1;
         tick();
      end
      n_chk++; if (!seen) begin n_fail++; $display("FAIL wrap_timeout: ack=%h required 80 within 20 cycles", ack); end
      #1;
      n_chk++; if (ack !== 8'h01) begin n_fail++; $display("FAIL wrap_second: ack=%h required 01", ack); end
      tick();
      req = 8'h03;
      #1;
      n_chk++; if (ack !== 8'h02) begin n_fail++; $display("FAIL wrap_ptr: ack=%h required 02", ack); end
      tick();
      req = '0;
   endtask

   task automatic test_reset_stall();
      do_reset();
      req = 8'hFF; out_ready = 1'b0; d = $urandom();
      #1;
      n_chk++; if (ack !== 8'h01) begin n_fail++; $display("FAIL rst_stall_first: ack=%h required 01", ack); end
      tick();
      req = 8'hFE;
      #1;
      n_chk++; if (y_valid !== 1'b1 || ack !== 8'h00) begin n_fail++; $display("FAIL rst_stall_pending: y_valid=%b ack=%h required 1 00", y_valid, ack); end
      rst_n = 1'b0;
      #1;
      n_chk++; if (ack !== 8'h00) begin n_fail++; $display("FAIL rst_stall_ack: ack=%h required 00", ack); end
      tick();
      rst_n = 1'b1; out_ready = 1'b1; req = 8'hFF;
      #1;
      n_chk++;
      if (y_valid !== 1'b0 || s !== 3'd0 || y !== '0) begin
         n_fail++; $display("FAIL rst_stall_out: y_valid=%b s=%0d y=%h required 0 0 0", y_valid, s, y);
      end
      n_chk++; if (ack !== 8'h01) begin n_fail++; $display("FAIL rst_stall_ptr: ack=%h required 01", ack); end
      tick();
      req = '0;
   endtask

`ifndef MUX_SKIP_IDLE_EN
   task automatic test_tdm();
      logic [7:0] e;
      int cnt;
      int last;
      do_reset();
      req = 8'h04; out_ready = 1'b1; cnt = 0; last = -1;
      for (int c = 0; c < 32; c++) begin
         d = $urandom();
         #1;
         e = exp_ack();
         n_chk++; if (ack !== e) begin n_fail++; $display("FAIL tdm_ack: cycle %0d ack=%h required %h", c, ack, e); end
         tick();
         n_chk++; if (y_valid !== m_valid) begin n_fail++; $display("FAIL tdm_valid: cycle %0d y_valid=%b required %b", c, y_valid, m_valid); end
         if (y_valid === 1'b1) begin
            cnt++;
            n_chk++; if (s !== 3'd2 || y !== m_y) begin n_fail++; $display("FAIL tdm_word: s=%0d y=%h required 2 %h", s, y, m_y); end
            if (last >= 0) begin
               n_chk++; if (c - last != 8) begin n_fail++; $display("FAIL tdm_spacing: gap=%0d required 8", c - last); end
            end
            last = c;
         end
      end
      n_chk++; if (cnt != 4) begin n_fail++; $display("FAIL tdm_count: words=%0d required 4", cnt); end
      req = '0;
   endtask
`endif

   // Sources hold req/d until acked; occasional resets land mid-traffic.
   task automatic test_random();
      logic [7:0] pend;
      logic [7:0] e;
      do_reset();
      pend = '0;
      for (int c = 0; c < 400; c++) begin
         for (int k = 0; k < 8; k++) begin
            if (m_ack[k] || !pend[k]) begin
               pend[k] = ($urandom_range(0, 2) == 0);
               if (pend[k]) d[k*DW +: DW] = DW'($urandom());
            end
         end
         req = pend;
         out_ready = ($urandom_range(0, 3) != 0);
         rst_n = ($urandom_range(0, 49) != 0);
         #1;
         e = exp_ack();
         n_chk++; if (ack !== e) begin n_fail++; $display("FAIL rand_ack: cycle %0d ack=%h required %h", c, ack, e); end
         n_chk++;
         if (y_valid !== m_valid || (m_valid && (y !== m_y || s !== 3'(m_s)))) begin
            n_fail++; $display("FAIL rand_out: cycle %0d y_valid=%b s=%0d y=%h required %b %0d %h", c, y_valid, s, y, m_valid, m_s, m_y);
         end
         tick();
      end
      rst_n = 1'b1; req = '0;
   endtask

   initial begin
      test_reset();
      test_single();
      test_all();
      test_stall();
      test_wrap();
      test_reset_stall();
`ifndef MUX_SKIP_IDLE_EN
      test_tdm();
`endif
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
